// File: rtl/rom_loader.sv
// Instruction ROM: loads a big-endian byte stream into word memory while holding
// the CPU in reset, then serves zero-latency fetches.
module rom_loader #(
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic [7:0]            load_data,
  input  logic                  load_last,
  output logic                  cpu_reset,
  input  logic                  rom_chip_enable,
  input  logic [31:0]           rom_address,
  output logic [31:0]           rom_data,
  output logic [DEPTH_LOG2:0]   words_loaded,
  output logic                  load_done
);

  localparam logic [DEPTH_LOG2:0] WordsMax = {1'b1, {DEPTH_LOG2{1'b0}}};

  typedef enum logic {StLoad, StRun} state_e;

  state_e                r_state;
  logic [1:0]            r_bc;
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [23:0]           r_partial;
  logic [DEPTH_LOG2:0]   r_words;
  logic                  r_cpu_reset;
  logic                  r_load_done;
  logic [31:0]           r_mem [0:(1 << DEPTH_LOG2) - 1];

  logic                  w_accept;
  logic                  w_write;
  logic [31:0]           w_word;
  logic [DEPTH_LOG2-1:0] w_index;
  logic                  w_read_ok;
  logic                  w_unused_addr;

  assign w_accept = load_valid && (r_state == StLoad) && !reset;
  assign w_write  = w_accept && ((r_bc == 2'd3) || load_last);

  // Lanes below the current byte are zero so a short final word is padded.
  always_comb begin
    w_word = 32'h0;
    case (r_bc)
      2'd0:    w_word = {load_data, 24'h0};
      2'd1:    w_word = {r_partial[23:16], load_data, 16'h0};
      2'd2:    w_word = {r_partial[23:8], load_data, 8'h0};
      default: w_word = {r_partial, load_data};
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StLoad;
      r_bc        <= 2'd0;
      r_wp        <= '0;
      r_partial   <= 24'h0;
      r_words     <= '0;
      r_cpu_reset <= 1'b1;
      r_load_done <= 1'b0;
    end else if (w_accept) begin
      if (w_write) begin
        r_bc <= 2'd0;
        r_wp <= r_wp + 1'b1;
        if (r_words != WordsMax) r_words <= r_words + 1'b1;
        if (load_last || (r_wp == '1)) begin
          r_state     <= StRun;
          r_cpu_reset <= 1'b0;
          r_load_done <= 1'b1;
        end
      end else begin
        r_bc <= r_bc + 2'd1;
        case (r_bc)
          2'd0:    r_partial[23:16] <= load_data;
          2'd1:    r_partial[15:8]  <= load_data;
          default: r_partial[7:0]   <= load_data;
        endcase
      end
    end
  end

  // Memory is never cleared; words_loaded alone decides what is valid.
  always_ff @(posedge clock) begin
    if (w_write) r_mem[r_wp] <= w_word;
  end

  assign w_index       = rom_address[DEPTH_LOG2+1:2];
  assign w_unused_addr = ^rom_address[1:0];
  assign w_read_ok     = (r_state == StRun) && rom_chip_enable
                         && (rom_address[31:DEPTH_LOG2+2] == '0)
                         && ({1'b0, w_index} < r_words);

  assign rom_data     = w_read_ok ? r_mem[w_index] : 32'h0;
  assign load_ready   = (r_state == StLoad);
  assign cpu_reset    = r_cpu_reset | reset;
  assign words_loaded = r_words;
  assign load_done    = r_load_done;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: default-depth instance A and a 4-word instance B.
module tb_rom_loader;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        a_reset, a_valid, a_last, a_ce, a_ready, a_cpu_reset, a_done;
  logic [7:0]  a_data;
  logic [31:0] a_addr, a_rdata;
  logic [10:0] a_words;

  logic        b_reset, b_valid, b_last, b_ce, b_ready, b_cpu_reset, b_done;
  logic [7:0]  b_data;
  logic [31:0] b_addr, b_rdata;
  logic [2:0]  b_words;

  rom_loader #(.DEPTH_LOG2(10)) u_dut_a (
    .clock           (clock),
    .reset           (a_reset),
    .load_valid      (a_valid),
    .load_ready      (a_ready),
    .load_data       (a_data),
    .load_last       (a_last),
    .cpu_reset       (a_cpu_reset),
    .rom_chip_enable (a_ce),
    .rom_address     (a_addr),
    .rom_data        (a_rdata),
    .words_loaded    (a_words),
    .load_done       (a_done)
  );

  rom_loader #(.DEPTH_LOG2(2)) u_dut_b (
    .clock           (clock),
    .reset           (b_reset),
    .load_valid      (b_valid),
    .load_ready      (b_ready),
    .load_data       (b_data),
    .load_last       (b_last),
    .cpu_reset       (b_cpu_reset),
    .rom_chip_enable (b_ce),
    .rom_address     (b_addr),
    .rom_data        (b_rdata),
    .words_loaded    (b_words),
    .load_done       (b_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference image: the byte stream as the loader should have received it.
  logic [7:0] model_bytes[$];

  function automatic logic [31:0] exp_word(input int k);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (4 * k + i < model_bytes.size()) w[31 - 8 * i -: 8] = model_bytes[4 * k + i];
    end
    return w;
  endfunction

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  task automatic a_read(input logic [31:0] addr, input logic ce, output logic [31:0] d);
    a_addr = addr;
    a_ce   = ce;
    #1;
    d = a_rdata;
  endtask

  task automatic b_read(input logic [31:0] addr, output logic [31:0] d);
    b_addr = addr;
    b_ce   = 1'b1;
    #1;
    d = b_rdata;
  endtask

  task automatic a_pulse_reset;
    a_valid = 1'b0;
    a_last  = 1'b0;
    a_reset = 1'b1;
    step;
    a_reset = 1'b0;
  endtask

  task automatic a_send(input logic [7:0] d, input logic last);
    a_valid = 1'b1;
    a_data  = d;
    a_last  = last;
    step;
    a_valid = 1'b0;
    a_last  = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] d;
    a_reset = 1'b1;
    step;
    step;
    a_reset = 1'b0;
    n_checks++;
    if (a_cpu_reset !== 1'b1) begin
      n_fail++; $display("FAIL reset_cpu_reset got %b want 1", a_cpu_reset);
    end
    n_checks++;
    if (a_words !== 11'd0) begin
      n_fail++; $display("FAIL reset_words got %0d want 0", a_words);
    end
    n_checks++;
    if (a_ready !== 1'b1 || a_done !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready_done got %b%b want 10", a_ready, a_done);
    end
    a_read(32'h0, 1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL reset_rom_data got %h want 00000000", d);
    end
  endtask

  task automatic test_basic;
    logic [31:0] d;
    model_bytes = '{8'h24, 8'h01, 8'h00, 8'h05, 8'h24, 8'h02, 8'h00, 8'h07};
    for (int i = 0; i < 8; i++) begin
      a_send(model_bytes[i], i == 7);
      if (i == 6) begin
        n_checks++;
        if (a_cpu_reset !== 1'b1) begin
          n_fail++; $display("FAIL basic_early_release got %b want 1", a_cpu_reset);
        end
      end
    end
    n_checks++;
    if (a_words !== 11'd2 || a_cpu_reset !== 1'b0 || a_done !== 1'b1 || a_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_finish got words=%0d cpu_reset=%b done=%b ready=%b want 2 0 1 0",
               a_words, a_cpu_reset, a_done, a_ready);
    end
    a_read(32'h0, 1'b1, d);
    n_checks++;
    if (d !== 32'h24010005) begin
      n_fail++; $display("FAIL basic_addr0 got %h want 24010005", d);
    end
    a_read(32'h4, 1'b1, d);
    n_checks++;
    if (d !== 32'h24020007) begin
      n_fail++; $display("FAIL basic_addr4 got %h want 24020007", d);
    end
    a_read(32'h8, 1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL basic_addr8 got %h want 00000000", d);
    end
  endtask

  task automatic test_partial;
    logic [31:0] d;
    a_pulse_reset;
    model_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA};
    for (int i = 0; i < 5; i++) a_send(model_bytes[i], i == 4);
    n_checks++;
    if (a_words !== 11'd2 || a_done !== 1'b1) begin
      n_fail++; $display("FAIL partial_words got %0d done=%b want 2 1", a_words, a_done);
    end
    a_read(32'h4, 1'b1, d);
    n_checks++;
    if (d !== 32'hAA000000) begin
      n_fail++; $display("FAIL partial_addr4 got %h want aa000000", d);
    end
    a_read(32'h0, 1'b1, d);
    n_checks++;
    if (d !== exp_word(0)) begin
      n_fail++; $display("FAIL partial_addr0 got %h want %h", d, exp_word(0));
    end
  endtask

  task automatic test_back_pressure;
    logic [31:0] d;
    logic        acc;
    int          idx;
    int          cycles;
    a_pulse_reset;
    model_bytes.delete();
    for (int i = 0; i < 12; i++) model_bytes.push_back(8'($urandom_range(0, 255)));
    idx    = 0;
    cycles = 0;
    while (idx < 12 && cycles < 200) begin
      a_valid = 1'($urandom_range(0, 1));
      a_data  = a_valid ? model_bytes[idx] : 8'($urandom_range(0, 255));
      a_last  = (idx == 11);
      n_checks++;
      if (a_ready !== 1'b1) begin
        n_fail++; $display("FAIL bp_ready byte %0d got %b want 1", idx, a_ready);
      end
      acc = a_valid && a_ready;
      step;
      if (acc) idx++;
      cycles++;
    end
    a_valid = 1'b0;
    a_last  = 1'b0;
    n_checks++;
    if (idx != 12) begin
      n_fail++; $display("FAIL bp_timeout got %0d bytes want 12", idx);
    end
    n_checks++;
    if (a_words !== 11'd3 || a_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_finish got words=%0d ready=%b want 3 0", a_words, a_ready);
    end
    for (int k = 0; k < 3; k++) begin
      a_read(32'(4 * k), 1'b1, d);
      n_checks++;
      if (d !== exp_word(k)) begin
        n_fail++; $display("FAIL bp_word%0d got %h want %h", k, d, exp_word(k));
      end
    end
  endtask

  task automatic test_read_gating;
    logic [31:0] d;
    a_read(32'h0, 1'b0, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL gate_ce_low got %h want 00000000", d);
    end
    a_read(32'h0000_1000, 1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL gate_high_addr got %h want 00000000", d);
    end
    a_read(32'h2, 1'b1, d);
    n_checks++;
    if (d !== exp_word(0)) begin
      n_fail++; $display("FAIL gate_addr2 got %h want %h", d, exp_word(0));
    end
    a_read(32'hB, 1'b1, d);
    n_checks++;
    if (d !== exp_word(2)) begin
      n_fail++; $display("FAIL gate_addrB got %h want %h", d, exp_word(2));
    end
    a_read(32'hC, 1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL gate_beyond got %h want 00000000", d);
    end
  endtask

  task automatic test_reset_mid_run;
    logic [31:0] d;
    a_pulse_reset;
    n_checks++;
    if (a_cpu_reset !== 1'b1 || a_words !== 11'd0 || a_ready !== 1'b1 || a_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reset got cpu_reset=%b words=%0d ready=%b done=%b want 1 0 1 0",
               a_cpu_reset, a_words, a_ready, a_done);
    end
    a_read(32'h0, 1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL midrun_addr0 got %h want 00000000", d);
    end
    model_bytes.delete();
    for (int i = 0; i < 4; i++) model_bytes.push_back(8'($urandom_range(0, 255)));
    for (int i = 0; i < 4; i++) a_send(model_bytes[i], i == 3);
    a_read(32'h0, 1'b1, d);
    n_checks++;
    if (d !== exp_word(0) || a_words !== 11'd1 || a_cpu_reset !== 1'b0) begin
      n_fail++;
      $display("FAIL midrun_reload got %h words=%0d cpu_reset=%b want %h 1 0",
               d, a_words, a_cpu_reset, exp_word(0));
    end
    a_read(32'h4, 1'b1, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL midrun_stale got %h want 00000000", d);
    end
  endtask

  task automatic test_full_memory;
    logic [31:0] d;
    int          acc;
    b_reset = 1'b1;
    step;
    b_reset = 1'b0;
    model_bytes.delete();
    for (int i = 0; i < 20; i++) model_bytes.push_back(8'($urandom_range(0, 255)));
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      b_valid = 1'b1;
      b_last  = 1'b0;
      b_data  = model_bytes[i];
      if (b_ready) acc++;
      step;
      if (i == 14) begin
        n_checks++;
        if (b_done !== 1'b0) begin
          n_fail++; $display("FAIL full_early_run got %b want 0", b_done);
        end
      end
      if (i == 15) begin
        n_checks++;
        if (b_done !== 1'b1 || b_words !== 3'd4 || b_ready !== 1'b0 || b_cpu_reset !== 1'b0) begin
          n_fail++;
          $display("FAIL full_enter_run got done=%b words=%0d ready=%b cpu_reset=%b want 1 4 0 0",
                   b_done, b_words, b_ready, b_cpu_reset);
        end
      end
    end
    b_valid = 1'b0;
    n_checks++;
    if (acc != 16 || b_words !== 3'd4) begin
      n_fail++; $display("FAIL full_accepted got %0d words=%0d want 16 4", acc, b_words);
    end
    for (int k = 0; k < 4; k++) begin
      b_read(32'(4 * k), d);
      n_checks++;
      if (d !== exp_word(k)) begin
        n_fail++; $display("FAIL full_word%0d got %h want %h", k, d, exp_word(k));
      end
    end
    b_read(32'h10, d);
    n_checks++;
    if (d !== 32'h0) begin
      n_fail++; $display("FAIL full_out_of_range got %h want 00000000", d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    a_reset = 1'b0; a_valid = 1'b0; a_last = 1'b0; a_data = 8'h0; a_ce = 1'b0; a_addr = 32'h0;
    b_reset = 1'b1; b_valid = 1'b0; b_last = 1'b0; b_data = 8'h0; b_ce = 1'b0; b_addr = 32'h0;
    test_reset;
    test_basic;
    test_partial;
    test_back_pressure;
    test_read_gating;
    test_reset_mid_run;
    test_full_memory;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rom_loader.md
# rom_loader

Instruction-ROM block feeding the CPU's instruction fetch port (`rom_chip_enable`, `rom_address`, `rom_data`). After reset it accepts a byte stream over a valid/ready handshake and assembles big-endian 32-bit words into an internal word memory. During the load it holds the CPU in reset. Once the load is complete it serves instruction reads combinationally, so the IF/ID latch captures `rom_data` in the same cycle that the PC is presented.

## Interface
- `DEPTH_LOG2`, default 10: log2 of the number of 32-bit words in the memory (default 1024 words).
- `clock`  in  1: single clock; all state changes on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `load_valid`  in  1: a byte is present on `load_data`.
- `load_ready`  out  1: the loader can accept a byte this cycle.
- `load_data`  in  8: byte stream, most-significant byte of each word first.
- `load_last`  in  1: qualifies the final byte of the image; sampled only on an accepted byte.
- `cpu_reset`  out  1: registered reset to the CPU; high until the load completes.
- `rom_chip_enable`  in  1: fetch enable from the CPU.
- `rom_address`  in  32: byte address from the CPU PC.
- `rom_data`  out  32: instruction word (combinational).
- `words_loaded`  out  DEPTH_LOG2+1: number of valid words in memory.
- `load_done`  out  1: high while in RUN.

## Operation
- Two-state FSM:
  - LOAD: entered on reset.
  - RUN: entered after the final word is written.
- Handshake:
  - A byte is accepted when `load_valid && load_ready`.
  - `load_ready` = (state == LOAD) and is independent of `load_valid`.
- Byte assembly:
  - A 2-bit byte counter `bc` selects the lane. Byte 0 goes to [31:24], byte 1 to [23:16], byte 2 to [15:8], byte 3 to [7:0].
  - Accepting the byte with `bc`==3 writes the assembled word to `mem[wp]`. `wp` then increments, `words_loaded` increments, and `bc` becomes 0.
- Last byte:
  - If an accepted byte has `load_last`=1 and `bc`<3, the word is written with the unfilled lower lanes zero-padded and counted as one word.
  - Any write caused by a `load_last` byte transitions the FSM to RUN.
- Full memory:
  - Writing word index 2^DEPTH_LOG2−1 transitions to RUN, even without `load_last`.
  - `words_loaded` saturates at 2^DEPTH_LOG2; it never wraps.
- Reads:
  - Word index = `rom_address[DEPTH_LOG2+1:2]`. `rom_address[1:0]` is ignored.
  - `rom_data` = `mem[index]` only when all of the following hold: state==RUN, `rom_chip_enable`=1, `rom_address[31:DEPTH_LOG2+2]`==0, and index < `words_loaded`.
  - In every other case `rom_data` = 32'h0, which is a MIPS nop.
- Reset behaviour:
  - Memory contents are not cleared by reset; they are invalidated by `words_loaded`=0.
  - Reset during LOAD discards any partial word and restarts at `wp`=0.
  - Reset during RUN returns to LOAD, reasserts `cpu_reset`, and requires a full reload.
- Bytes presented in RUN are not accepted and are not consumed.

## Timing
- Values under reset, applied on the next edge: state=LOAD, `bc`=0, `wp`=0, `words_loaded`=0, `cpu_reset`=1, `load_done`=0, `load_ready`=1, `rom_data`=0.
- Byte throughput: one byte per cycle; a full word takes 4 accepted bytes.
- Memory write occurs on the edge that accepts the completing byte. `words_loaded` updates on the same edge.
- FSM transition to RUN occurs on the edge that writes the final word. On that same edge:
  - `cpu_reset` falls;
  - `load_done` rises;
  - `load_ready` falls.
- Read latency is zero: the first fetch of address 0 is valid in the first cycle `cpu_reset`=0.
- While `reset`=1, `cpu_reset` is held high regardless of state.

## Test plan
- Load 8 bytes 24 01 00 05 / 24 02 00 07, with `load_last` on byte 8:
  - `words_loaded`=2 and `cpu_reset` falls on the 8th accept edge.
  - address 0 → 32'h24010005; address 4 → 32'h24020007; address 8 → 0.
- Partial word: load 5 bytes 11 22 33 44 AA, with `load_last` on AA:
  - `words_loaded`=2 and address 4 → 32'hAA000000.
- Back-pressure and gaps: toggle `load_valid` randomly while loading 3 words:
  - no byte is lost or duplicated; the contents match byte for byte.
  - `load_ready` stays high until the final accept.
- Full memory with DEPTH_LOG2=2: stream 20 bytes with no `load_last`:
  - RUN is entered after 16 bytes; `words_loaded`=4; `load_ready`=0; bytes 17–20 are not accepted.
- Read gating in RUN:
  - `rom_chip_enable`=0 → 0.
  - address 32'h0000_1000 with DEPTH_LOG2=10 → 0.
  - address 2 returns the word at index 0.
- Reset mid-run:
  - After a loaded RUN, assert `reset` for 1 cycle: `cpu_reset`=1, `words_loaded`=0, address 0 → 0, `load_ready`=1.
  - Reload 4 bytes with `load_last`: the new word is read back at address 0.
